tlb_table: RTL and testbench
============================

Name: tlb_table

Overview:
- Joint TLB array on the CP0 TLB interface.
- Consumes the CP0 EntryHi/EntryLo0/EntryLo1/PageMask/Index/Random outputs and executes tlbwi/tlbwr writes.
- Returns tlbp/tlbr results to the CP0 (index_in, entry_*_in, page_mask_in).
- Provides the instruction-side and data-side virtual-to-physical translation, plus the TLB exception flags used by the exception path.

Parameters:
- TLB_LINE_NUM, 16, number of entries; must be a power of 2; matches the CP0 Random range.
- IDX_W, 4, log2(TLB_LINE_NUM).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stallM  in  1  M stage stalled; suppresses array writes
- tlb_typeM  in  4  {tlbwr, tlbwi, tlbr, tlbp}, at most one bit set
- entry_hi_W  in  32  CP0 EntryHi: VPN2 [31:13], ASID [7:0]
- entry_lo0_W, entry_lo1_W  in  32 each  CP0 EntryLo: PFN [25:6], C [5:3], D [2], V [1], G [0]
- page_mask_W  in  32  CP0 PageMask: Mask [24:13]
- index_W  in  32  CP0 Index; the low IDX_W bits are used
- random_W  in  32  CP0 Random; the low IDX_W bits are used
- index_in  out  32  tlbp result: bit 31 = P (1 means miss), low IDX_W bits = hit index, other bits 0
- entry_hi_in, entry_lo0_in, entry_lo1_in, page_mask_in  out  32 each  tlbr result in CP0 field layout; unused bits 0
- inst_vaddr  in  32  fetch virtual address
- inst_paddr  out  32  fetch physical address
- inst_uncached  out  1  fetch is uncached
- inst_refill  out  1  fetch missed the TLB (mapped address, no match)
- inst_invalid  out  1  fetch matched an entry whose selected V = 0
- data_vaddr  in  32  load/store virtual address
- data_en  in  1  memory access valid; qualifies the data_* flags
- data_wr  in  1  access is a store
- data_paddr  out  32  data physical address
- data_uncached  out  1  data access is uncached
- data_refill, data_invalid, data_modified  out  1 each  data-side TLB exception flags

Behaviour:
- Entry format: VPN2[18:0], ASID[7:0], G, PageMask[11:0], and per page {PFN[19:0], C[2:0], D, V}.
- Array reset:
  - On rst, all fields of all entries clear to 0.
  - The array is the only sequential state.
- Array write:
  - At posedge clk, when (tlbwi | tlbwr) & ~stallM & ~rst, the entry at idx is written from the CP0 inputs.
  - idx = index_W[IDX_W-1:0] for tlbwi, random_W[IDX_W-1:0] for tlbwr.
  - G = entry_lo0_W[0] & entry_lo1_W[0].
  - The written value is visible to all lookups from the next cycle; a same-cycle lookup sees the old contents.
- Match rule:
  - An entry matches when entry.VPN2 == va[31:13] and (entry.G or entry.ASID == entry_hi_W[7:0]).
  - Only 4 KB pages are supported: PageMask is stored and returned by tlbr but is ignored in matching.
  - va[12] selects the odd (1) or even (0) page.
  - With multiple matches, the lowest index wins.
- tlbp (combinational, same cycle):
  - va = entry_hi_W.
  - Hit: index_in = {1'b0, zeros, hit_idx}.
  - Miss: index_in = 32'h8000_0000.
  - index_in is driven continuously; the CP0 samples it only when tlbp is set.
- tlbr (combinational):
  - Reads entry index_W[IDX_W-1:0].
  - entry_hi_in = {VPN2, 5'b0, ASID}.
  - entry_lo0_in/entry_lo1_in = {6'b0, PFN, C, D, V, G}.
  - page_mask_in = {7'b0, Mask, 13'b0}.
- Translation (combinational, identical for the inst and data ports):
  - va[31:30] == 2'b10 (kseg0/kseg1): paddr = {3'b000, va[28:0]}; no TLB flags.
  - kseg0 is cached, kseg1 is uncached.
  - All other addresses are mapped: paddr = {PFN_sel, va[11:0]}; uncached = (C_sel == 3'b010).
  - Mapped miss: refill = 1 and paddr = 0.
  - Mapped hit with V_sel = 0: invalid = 1.
  - Data port only: hit with V_sel = 1, data_wr = 1 and D_sel = 0 gives data_modified = 1.
  - All data flags are gated by data_en; when data_en = 0, every data flag is 0.
- Flag exclusivity: refill, invalid and modified are mutually exclusive; priority is refill > invalid > modified.
- Reset mid-operation: rst has priority over a concurrent write; there are no pending operations.

Decomposition:
- Shared package (defines.vh) holds:
  - TLB_LINE_NUM
  - EntryHi/EntryLo/PageMask/Index field ranges (VPN2_BITS, ASID_BITS, PFN_BITS, FLAG_BITS, MASK_BITS, INDEX_BITS)
  - the uncached C encoding 3'b010
  - the TLB type bit order.
- One sub-module, tlb_lookup:
  - A combinational match, priority encode and page select for one virtual address.
  - Instantiated three times: inst, data and tlbp.

Test Plan:
- Reset, then tlbp with entry_hi_W = 32'h0040_0001 -> index_in = 32'h8000_0000; inst_vaddr = 32'h0040_0000 -> inst_refill = 1.
- tlbwi with index_W = 3, entry_hi_W = 32'h0040_0001, lo0 = 32'h0000_1017 (PFN 0x40, C = 2, D = 1, V = 1, G = 1), lo1 = 32'h0000_1056 (PFN 0x41, C = 2, D = 1, V = 1, G = 0):
  - Then inst_vaddr = 32'h0040_0123 -> inst_paddr = 32'h0004_0123, inst_uncached = 1.
  - Then inst_vaddr = 32'h0040_1123 -> inst_paddr = 32'h0004_1123.
  - Then tlbp -> index_in = 32'h0000_0003.
- Write an entry with lo1 D = 0, V = 1; data_en = 1, data_wr = 1 to the odd page -> data_modified = 1. Repeat with data_wr = 0 -> all data flags 0.
- Write an entry with G = 0, ASID = 5, then set entry_hi_W ASID = 6 -> mapped lookup gives refill. Set ASID back to 5 -> hit.
- tlbwr with random_W = 9 and stallM = 1 -> entry 9 unchanged (tlbr at index 9 reads zeros). With stallM = 0 -> tlbr returns the written fields. A lookup in the write cycle returns the old result.
- data_vaddr = 32'hA000_1000 (kseg1) -> data_paddr = 32'h0000_1000, data_uncached = 1, no flags. data_vaddr = 32'h8000_1000 (kseg0) -> same paddr, data_uncached = 0.

Source files
------------

// File: rtl/tlb_table_pkg.sv
// Shared TLB definitions: geometry, CP0 register field layout, entry format.
package tlb_table_pkg;

  localparam int unsigned TLB_LINE_NUM = 16;
  localparam int unsigned IDX_W        = 4;

  // CP0 register field widths and least-significant bit positions.
  localparam int unsigned VPN2_BITS  = 19;
  localparam int unsigned VPN2_LSB   = 13;
  localparam int unsigned ASID_BITS  = 8;
  localparam int unsigned PFN_BITS   = 20;
  localparam int unsigned PFN_LSB    = 6;
  localparam int unsigned FLAG_BITS  = 6;   // C[2:0], D, V, G
  localparam int unsigned MASK_BITS  = 12;
  localparam int unsigned MASK_LSB   = 13;
  localparam int unsigned INDEX_BITS = IDX_W;
  localparam int unsigned INDEX_P    = 31;

  localparam logic [2:0] CACHE_UNCACHED = 3'b010;

  // Bit positions inside tlb_typeM.
  localparam int unsigned TLB_P  = 0;
  localparam int unsigned TLB_R  = 1;
  localparam int unsigned TLB_WI = 2;
  localparam int unsigned TLB_WR = 3;

  typedef struct packed {
    logic [PFN_BITS-1:0] pfn;
    logic [2:0]          c;
    logic                d;
    logic                v;
  } tlb_page_t;

  typedef struct packed {
    logic [VPN2_BITS-1:0] vpn2;
    logic [ASID_BITS-1:0] asid;
    logic                 g;
    logic [MASK_BITS-1:0] mask;
    tlb_page_t            page1;
    tlb_page_t            page0;
  } tlb_entry_t;

  localparam int unsigned ENTRY_W = $bits(tlb_entry_t);

  // Builds an EntryLo value from one page plus the entry-wide G bit.
  function automatic logic [31:0] pack_lo(tlb_page_t p, logic g);
    return {6'b0, p.pfn, p.c, p.d, p.v, g};
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Fully associative match of one VPN2/ASID against the array; lowest index wins,
// then the even or odd page of the winning entry is selected.
module tlb_lookup
  import tlb_table_pkg::*;
(
  input  logic [TLB_LINE_NUM-1:0][ENTRY_W-1:0] entries_i,
  input  logic [VPN2_BITS-1:0]                 vpn2_i,
  input  logic                                 odd_i,
  input  logic [ASID_BITS-1:0]                 asid_i,
  output logic                                 hit_o,
  output logic [IDX_W-1:0]                     idx_o,
  output logic [PFN_BITS-1:0]                  pfn_o,
  output logic [2:0]                           c_o,
  output logic                                 d_o,
  output logic                                 v_o
);

  tlb_entry_t entry;
  tlb_entry_t match;
  tlb_page_t  page;

  // Scan from the top down so the lowest matching index is the last one kept.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    match = '0;
    entry = '0;
    for (int i = TLB_LINE_NUM - 1; i >= 0; i--) begin
      entry = tlb_entry_t'(entries_i[i]);
      if (entry.vpn2 == vpn2_i && (entry.g || entry.asid == asid_i)) begin
        hit_o = 1'b1;
        idx_o = i[IDX_W-1:0];
        match = entry;
      end
    end
  end

  // Odd/even page select from va[12].
  always_comb begin
    page  = odd_i ? match.page1 : match.page0;
    pfn_o = page.pfn;
    c_o   = page.c;
    d_o   = page.d;
    v_o   = page.v;
  end

endmodule

// File: rtl/tlb_table.sv
// Joint TLB: CP0 tlbwi/tlbwr/tlbr/tlbp support plus instruction and data address
// translation with refill/invalid/modified exception flags.
module tlb_table
  import tlb_table_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM,
  input  logic [3:0]  tlb_typeM,
  input  logic [31:0] entry_hi_W,
  input  logic [31:0] entry_lo0_W,
  input  logic [31:0] entry_lo1_W,
  input  logic [31:0] page_mask_W,
  input  logic [31:0] index_W,
  input  logic [31:0] random_W,
  output logic [31:0] index_in,
  output logic [31:0] entry_hi_in,
  output logic [31:0] entry_lo0_in,
  output logic [31:0] entry_lo1_in,
  output logic [31:0] page_mask_in,
  input  logic [31:0] inst_vaddr,
  output logic [31:0] inst_paddr,
  output logic        inst_uncached,
  output logic        inst_refill,
  output logic        inst_invalid,
  input  logic [31:0] data_vaddr,
  input  logic        data_en,
  input  logic        data_wr,
  output logic [31:0] data_paddr,
  output logic        data_uncached,
  output logic        data_refill,
  output logic        data_invalid,
  output logic        data_modified
);

  tlb_entry_t [TLB_LINE_NUM-1:0] entries_q, entries_d;
  tlb_entry_t                    new_entry, rd_entry;
  logic                          wr_en;
  logic [IDX_W-1:0]              wr_idx;
  logic [ASID_BITS-1:0]          cur_asid;

  assign cur_asid = entry_hi_W[ASID_BITS-1:0];
  assign wr_en    = (tlb_typeM[TLB_WI] | tlb_typeM[TLB_WR]) & ~stallM;
  assign wr_idx   = tlb_typeM[TLB_WR] ? random_W[IDX_W-1:0] : index_W[IDX_W-1:0];

  // Assemble the entry image from the CP0 registers.
  always_comb begin
    new_entry            = '0;
    new_entry.vpn2       = entry_hi_W[VPN2_LSB +: VPN2_BITS];
    new_entry.asid       = cur_asid;
    new_entry.g          = entry_lo0_W[0] & entry_lo1_W[0];
    new_entry.mask       = page_mask_W[MASK_LSB +: MASK_BITS];
    new_entry.page0.pfn  = entry_lo0_W[PFN_LSB +: PFN_BITS];
    new_entry.page0.c    = entry_lo0_W[5:3];
    new_entry.page0.d    = entry_lo0_W[2];
    new_entry.page0.v    = entry_lo0_W[1];
    new_entry.page1.pfn  = entry_lo1_W[PFN_LSB +: PFN_BITS];
    new_entry.page1.c    = entry_lo1_W[5:3];
    new_entry.page1.d    = entry_lo1_W[2];
    new_entry.page1.v    = entry_lo1_W[1];
  end

  // Next array contents: one entry replaced on an unstalled tlbwi/tlbwr.
  always_comb begin
    entries_d = entries_q;
    if (wr_en) begin
      entries_d[wr_idx] = new_entry;
    end
  end

  // Array state; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  // Three lookup ports: fetch, load/store, and tlbp probe.
  logic                i_hit, d_hit, p_hit;
  logic [IDX_W-1:0]    i_idx, d_idx, p_idx;
  logic [PFN_BITS-1:0] i_pfn, d_pfn, p_pfn;
  logic [2:0]          i_c, d_c, p_c;
  logic                i_d, d_d, p_d;
  logic                i_v, d_v, p_v;

  tlb_lookup u_inst_lookup (
    .entries_i (entries_q),
    .vpn2_i    (inst_vaddr[VPN2_LSB +: VPN2_BITS]),
    .odd_i     (inst_vaddr[12]),
    .asid_i    (cur_asid),
    .hit_o     (i_hit),
    .idx_o     (i_idx),
    .pfn_o     (i_pfn),
    .c_o       (i_c),
    .d_o       (i_d),
    .v_o       (i_v)
  );

  tlb_lookup u_data_lookup (
    .entries_i (entries_q),
    .vpn2_i    (data_vaddr[VPN2_LSB +: VPN2_BITS]),
    .odd_i     (data_vaddr[12]),
    .asid_i    (cur_asid),
    .hit_o     (d_hit),
    .idx_o     (d_idx),
    .pfn_o     (d_pfn),
    .c_o       (d_c),
    .d_o       (d_d),
    .v_o       (d_v)
  );

  tlb_lookup u_probe_lookup (
    .entries_i (entries_q),
    .vpn2_i    (entry_hi_W[VPN2_LSB +: VPN2_BITS]),
    .odd_i     (entry_hi_W[12]),
    .asid_i    (cur_asid),
    .hit_o     (p_hit),
    .idx_o     (p_idx),
    .pfn_o     (p_pfn),
    .c_o       (p_c),
    .d_o       (p_d),
    .v_o       (p_v)
  );

  // tlbp result and tlbr readback in CP0 field layout.
  always_comb begin
    index_in     = p_hit ? {1'b0, {(31 - IDX_W){1'b0}}, p_idx} : 32'h8000_0000;
    rd_entry     = entries_q[index_W[IDX_W-1:0]];
    entry_hi_in  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
    entry_lo0_in = pack_lo(rd_entry.page0, rd_entry.g);
    entry_lo1_in = pack_lo(rd_entry.page1, rd_entry.g);
    page_mask_in = {7'b0, rd_entry.mask, 13'b0};
  end

  // Fetch translation: kseg0/kseg1 bypass the TLB, va[29] picks kseg1 (uncached).
  always_comb begin
    inst_paddr    = '0;
    inst_uncached = 1'b0;
    inst_refill   = 1'b0;
    inst_invalid  = 1'b0;
    if (inst_vaddr[31:30] == 2'b10) begin
      inst_paddr    = {3'b000, inst_vaddr[28:0]};
      inst_uncached = inst_vaddr[29];
    end else if (!i_hit) begin
      inst_refill = 1'b1;
    end else begin
      inst_paddr    = {i_pfn, inst_vaddr[11:0]};
      inst_uncached = (i_c == CACHE_UNCACHED);
      inst_invalid  = ~i_v;
    end
  end

  // Data translation; exception flags only raised for a valid access.
  always_comb begin
    data_paddr    = '0;
    data_uncached = 1'b0;
    data_refill   = 1'b0;
    data_invalid  = 1'b0;
    data_modified = 1'b0;
    if (data_vaddr[31:30] == 2'b10) begin
      data_paddr    = {3'b000, data_vaddr[28:0]};
      data_uncached = data_vaddr[29];
    end else if (!d_hit) begin
      data_refill = data_en;
    end else begin
      data_paddr    = {d_pfn, data_vaddr[11:0]};
      data_uncached = (d_c == CACHE_UNCACHED);
      data_invalid  = data_en & ~d_v;
      data_modified = data_en & d_v & data_wr & ~d_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{tlb_typeM[TLB_R], tlb_typeM[TLB_P], index_W[31:IDX_W],
                         random_W[31:IDX_W], entry_hi_W[11:8], entry_lo0_W[31:26],
                         entry_lo1_W[31:26], page_mask_W[31:25], page_mask_W[12:0],
                         i_idx, d_idx, p_pfn, p_c, p_d, p_v};

endmodule

// File: tb/tb_tlb_table.sv
// Testbench for tlb_table: directed scenarios plus randomized traffic checked
// against an array-based reference model of the TLB.
module tb_tlb_table;

  logic        clk, rst, stallM;
  logic [3:0]  tlb_typeM;
  logic [31:0] entry_hi_W, entry_lo0_W, entry_lo1_W, page_mask_W, index_W, random_W;
  logic [31:0] index_in, entry_hi_in, entry_lo0_in, entry_lo1_in, page_mask_in;
  logic [31:0] inst_vaddr, inst_paddr, data_vaddr, data_paddr;
  logic        inst_uncached, inst_refill, inst_invalid;
  logic        data_en, data_wr, data_uncached, data_refill, data_invalid, data_modified;

  localparam logic [3:0] WI = 4'b0100;
  localparam logic [3:0] WR = 4'b1000;

  int n_pass = 0;
  int n_total = 0;

  tlb_table dut (
    .clk(clk), .rst(rst), .stallM(stallM), .tlb_typeM(tlb_typeM),
    .entry_hi_W(entry_hi_W), .entry_lo0_W(entry_lo0_W), .entry_lo1_W(entry_lo1_W),
    .page_mask_W(page_mask_W), .index_W(index_W), .random_W(random_W),
    .index_in(index_in), .entry_hi_in(entry_hi_in), .entry_lo0_in(entry_lo0_in),
    .entry_lo1_in(entry_lo1_in), .page_mask_in(page_mask_in),
    .inst_vaddr(inst_vaddr), .inst_paddr(inst_paddr), .inst_uncached(inst_uncached),
    .inst_refill(inst_refill), .inst_invalid(inst_invalid),
    .data_vaddr(data_vaddr), .data_en(data_en), .data_wr(data_wr),
    .data_paddr(data_paddr), .data_uncached(data_uncached), .data_refill(data_refill),
    .data_invalid(data_invalid), .data_modified(data_modified)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per TLB line, pages indexed 0 (even) / 1 (odd).
  logic [18:0] m_vpn2 [16];
  logic [7:0]  m_asid [16];
  logic        m_g    [16];
  logic [11:0] m_mask [16];
  logic [19:0] m_pfn  [16][2];
  logic [2:0]  m_c    [16][2];
  logic        m_d    [16][2];
  logic        m_v    [16][2];

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_mask[i] = '0;
      for (int p = 0; p < 2; p++) begin
        m_pfn[i][p] = '0; m_c[i][p] = '0; m_d[i][p] = 1'b0; m_v[i][p] = 1'b0;
      end
    end
  endtask

  task automatic model_write(input int i, input logic [31:0] hi, input logic [31:0] lo0,
                             input logic [31:0] lo1, input logic [31:0] pm);
    m_vpn2[i] = hi[31:13];
    m_asid[i] = hi[7:0];
    m_g[i]    = lo0[0] & lo1[0];
    m_mask[i] = pm[24:13];
    m_pfn[i][0] = lo0[25:6]; m_c[i][0] = lo0[5:3]; m_d[i][0] = lo0[2]; m_v[i][0] = lo0[1];
    m_pfn[i][1] = lo1[25:6]; m_c[i][1] = lo1[5:3]; m_d[i][1] = lo1[2]; m_v[i][1] = lo1[1];
  endtask

  task automatic model_find(input logic [18:0] vpn, input logic [7:0] asid,
                            output logic found, output int k);
    found = 1'b0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (!found && m_vpn2[i] == vpn && (m_g[i] || m_asid[i] == asid)) begin
        found = 1'b1;
        k = i;
      end
    end
  endtask

  task automatic model_xlate(input logic [31:0] va, input logic [7:0] asid, input logic en,
                             input logic wr, output logic [31:0] pa, output logic unc,
                             output logic rf, output logic iv, output logic md);
    logic found;
    int   k;
    int   p;
    pa = 32'h0; unc = 1'b0; rf = 1'b0; iv = 1'b0; md = 1'b0;
    if (va[31:30] == 2'b10) begin
      pa  = {3'b000, va[28:0]};
      unc = (va[31:29] == 3'b101);
    end else begin
      model_find(va[31:13], asid, found, k);
      if (!found) begin
        rf = en;
      end else begin
        p   = va[12] ? 1 : 0;
        pa  = {m_pfn[k][p], va[11:0]};
        unc = (m_c[k][p] == 3'd2);
        iv  = en && !m_v[k][p];
        md  = en && m_v[k][p] && wr && !m_d[k][p];
      end
    end
  endtask

  task automatic tlb_write(input logic [3:0] typ, input logic [3:0] idx, input logic [31:0] hi,
                           input logic [31:0] lo0, input logic [31:0] lo1,
                           input logic [31:0] pm, input logic stall);
    logic [31:0] r;
    r = $urandom();
    @(negedge clk);
    tlb_typeM = typ;
    // The unselected index source points elsewhere so a wrong choice is visible.
    if (typ == WR) begin
      random_W = {r[31:4], idx};
      index_W  = {r[27:0], ~idx};
    end else begin
      index_W  = {r[31:4], idx};
      random_W = {r[27:0], ~idx};
    end
    entry_hi_W = hi; entry_lo0_W = lo0; entry_lo1_W = lo1; page_mask_W = pm;
    stallM = stall;
    @(posedge clk);
    if (!stall) model_write(idx, hi, lo0, lo1, pm);
    #1;
    tlb_typeM = 4'b0;
    stallM = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    entry_hi_W = 32'h0040_0001; inst_vaddr = 32'h0040_0000; index_W = 32'd0;
    #1;
    n_total++; if (index_in !== 32'h8000_0000) $display("FAIL reset_tlbp: got %h want 80000000", index_in); else n_pass++;
    n_total++; if (inst_refill !== 1'b1) $display("FAIL reset_refill: got %b want 1", inst_refill); else n_pass++;
    n_total++; if (inst_paddr !== 32'h0) $display("FAIL reset_paddr: got %h want 0", inst_paddr); else n_pass++;
    n_total++; if (entry_lo0_in !== 32'h0) $display("FAIL reset_tlbr_lo0: got %h want 0", entry_lo0_in); else n_pass++;
  endtask

  task automatic test_tlbwi();
    tlb_write(WI, 4'd3, 32'h0040_0001, 32'h0000_1017, 32'h0000_1056, 32'h0, 1'b0);
    @(negedge clk);
    entry_hi_W = 32'h0040_0001; index_W = 32'd3; inst_vaddr = 32'h0040_0123;
    #1;
    n_total++; if (inst_paddr !== 32'h0004_0123) $display("FAIL wi_even_paddr: got %h want 00040123", inst_paddr); else n_pass++;
    n_total++; if (inst_uncached !== 1'b1) $display("FAIL wi_uncached: got %b want 1", inst_uncached); else n_pass++;
    n_total++; if (inst_refill !== 1'b0) $display("FAIL wi_refill: got %b want 0", inst_refill); else n_pass++;
    n_total++; if (index_in !== 32'h0000_0003) $display("FAIL wi_tlbp: got %h want 00000003", index_in); else n_pass++;
    n_total++; if (entry_hi_in !== 32'h0040_0001) $display("FAIL wi_tlbr_hi: got %h want 00400001", entry_hi_in); else n_pass++;
    n_total++; if (entry_lo0_in !== 32'h0000_1016) $display("FAIL wi_tlbr_lo0: got %h want 00001016", entry_lo0_in); else n_pass++;
    n_total++; if (entry_lo1_in !== 32'h0000_1056) $display("FAIL wi_tlbr_lo1: got %h want 00001056", entry_lo1_in); else n_pass++;
    inst_vaddr = 32'h0040_1123;
    #1;
    n_total++; if (inst_paddr !== 32'h0004_1123) $display("FAIL wi_odd_paddr: got %h want 00041123", inst_paddr); else n_pass++;
  endtask

  task automatic test_priority();
    tlb_write(WI, 4'd12, 32'h0040_0001, 32'h0000_5016, 32'h0000_5056, 32'h0, 1'b0);
    @(negedge clk);
    entry_hi_W = 32'h0040_0001; inst_vaddr = 32'h0040_0123;
    #1;
    n_total++; if (index_in !== 32'h0000_0003) $display("FAIL prio_tlbp_3: got %h want 00000003", index_in); else n_pass++;
    n_total++; if (inst_paddr !== 32'h0004_0123) $display("FAIL prio_paddr_3: got %h want 00040123", inst_paddr); else n_pass++;
    tlb_write(WI, 4'd2, 32'h0040_0001, 32'h0000_6016, 32'h0000_6056, 32'h0, 1'b0);
    @(negedge clk);
    inst_vaddr = 32'h0040_0123;
    #1;
    n_total++; if (index_in !== 32'h0000_0002) $display("FAIL prio_tlbp_2: got %h want 00000002", index_in); else n_pass++;
    n_total++; if (inst_paddr !== 32'h0018_0123) $display("FAIL prio_paddr_2: got %h want 00180123", inst_paddr); else n_pass++;
  endtask

  task automatic test_modified();
    tlb_write(WI, 4'd5, 32'h0080_0005, 32'h0000_2002, 32'h0000_2042, 32'h0, 1'b0);
    @(negedge clk);
    entry_hi_W = 32'h0080_0005; data_vaddr = 32'h0080_1010; data_en = 1'b1; data_wr = 1'b1;
    #1;
    n_total++; if (data_modified !== 1'b1) $display("FAIL mod_store: got %b want 1", data_modified); else n_pass++;
    n_total++; if (data_paddr !== 32'h0008_1010) $display("FAIL mod_paddr: got %h want 00081010", data_paddr); else n_pass++;
    n_total++; if ({data_refill, data_invalid} !== 2'b00) $display("FAIL mod_other_flags: got %b want 00", {data_refill, data_invalid}); else n_pass++;
    data_wr = 1'b0;
    #1;
    n_total++; if ({data_refill, data_invalid, data_modified} !== 3'b000) $display("FAIL mod_load: got %b want 000", {data_refill, data_invalid, data_modified}); else n_pass++;
    data_wr = 1'b1; data_en = 1'b0;
    #1;
    n_total++; if (data_modified !== 1'b0) $display("FAIL mod_gated: got %b want 0", data_modified); else n_pass++;
  endtask

  task automatic test_asid();
    @(negedge clk);
    entry_hi_W = 32'h0080_0006; inst_vaddr = 32'h0080_0000;
    #1;
    n_total++; if (inst_refill !== 1'b1) $display("FAIL asid_mismatch: got %b want 1", inst_refill); else n_pass++;
    entry_hi_W = 32'h0080_0005;
    #1;
    n_total++; if (inst_refill !== 1'b0) $display("FAIL asid_match_refill: got %b want 0", inst_refill); else n_pass++;
    n_total++; if (inst_paddr !== 32'h0008_0000) $display("FAIL asid_match_paddr: got %h want 00080000", inst_paddr); else n_pass++;
  endtask

  task automatic test_invalid();
    tlb_write(WI, 4'd7, 32'h0100_0005, 32'h0000_3000, 32'h0000_3042, 32'h0, 1'b0);
    @(negedge clk);
    entry_hi_W = 32'h0100_0005; data_vaddr = 32'h0100_0000; data_en = 1'b1; data_wr = 1'b1;
    inst_vaddr = 32'h0100_0000;
    #1;
    n_total++; if ({data_refill, data_invalid, data_modified} !== 3'b010) $display("FAIL inv_data_flags: got %b want 010", {data_refill, data_invalid, data_modified}); else n_pass++;
    n_total++; if (inst_invalid !== 1'b1) $display("FAIL inv_inst: got %b want 1", inst_invalid); else n_pass++;
  endtask

  task automatic test_tlbwr();
    tlb_write(WR, 4'd9, 32'h0200_0005, 32'h0000_4017, 32'h0000_4057, 32'h01FF_E000, 1'b1);
    @(negedge clk);
    index_W = 32'd9;
    #1;
    n_total++; if ({entry_hi_in, entry_lo0_in, page_mask_in} !== 96'h0) $display("FAIL wr_stalled: got %h want 0", {entry_hi_in, entry_lo0_in, page_mask_in}); else n_pass++;
    // Lookup in the write cycle must still see the old array.
    @(negedge clk);
    tlb_typeM = WR; random_W = 32'd9; index_W = 32'd9; stallM = 1'b0;
    entry_hi_W = 32'h0200_0005; entry_lo0_W = 32'h0000_4017; entry_lo1_W = 32'h0000_4057;
    page_mask_W = 32'h01FF_E000; inst_vaddr = 32'h0200_0040;
    #1;
    n_total++; if (inst_refill !== 1'b1) $display("FAIL wr_same_cycle: got %b want 1", inst_refill); else n_pass++;
    @(posedge clk);
    model_write(9, 32'h0200_0005, 32'h0000_4017, 32'h0000_4057, 32'h01FF_E000);
    #1;
    tlb_typeM = 4'b0;
    n_total++; if (inst_refill !== 1'b0) $display("FAIL wr_next_refill: got %b want 0", inst_refill); else n_pass++;
    n_total++; if (inst_paddr !== 32'h0010_0040) $display("FAIL wr_next_paddr: got %h want 00100040", inst_paddr); else n_pass++;
    n_total++; if (entry_hi_in !== 32'h0200_0005) $display("FAIL wr_tlbr_hi: got %h want 02000005", entry_hi_in); else n_pass++;
    n_total++; if (entry_lo0_in !== 32'h0000_4017) $display("FAIL wr_tlbr_lo0: got %h want 00004017", entry_lo0_in); else n_pass++;
    n_total++; if (entry_lo1_in !== 32'h0000_4057) $display("FAIL wr_tlbr_lo1: got %h want 00004057", entry_lo1_in); else n_pass++;
    n_total++; if (page_mask_in !== 32'h01FF_E000) $display("FAIL wr_tlbr_mask: got %h want 01ffe000", page_mask_in); else n_pass++;
  endtask

  task automatic test_kseg();
    @(negedge clk);
    data_en = 1'b1; data_wr = 1'b1; data_vaddr = 32'hA000_1000;
    #1;
    n_total++; if (data_paddr !== 32'h0000_1000) $display("FAIL kseg1_paddr: got %h want 00001000", data_paddr); else n_pass++;
    n_total++; if (data_uncached !== 1'b1) $display("FAIL kseg1_uncached: got %b want 1", data_uncached); else n_pass++;
    n_total++; if ({data_refill, data_invalid, data_modified} !== 3'b000) $display("FAIL kseg1_flags: got %b want 000", {data_refill, data_invalid, data_modified}); else n_pass++;
    data_vaddr = 32'h8000_1000;
    #1;
    n_total++; if (data_paddr !== 32'h0000_1000) $display("FAIL kseg0_paddr: got %h want 00001000", data_paddr); else n_pass++;
    n_total++; if (data_uncached !== 1'b0) $display("FAIL kseg0_uncached: got %b want 0", data_uncached); else n_pass++;
  endtask

  function automatic logic [18:0] pool_vpn(input int k);
    case (k)
      6:       return 19'h4_0000;  // kseg0 region: never translated, still probed
      7:       return 19'h7_FFF0;  // kseg2/3: mapped
      default: return 19'(k * 3 + 1);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] r, lo0, lo1, e_pa;
    logic        e_unc, e_rf, e_iv, e_md, found;
    int          k;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom(); lo0 = $urandom(); lo1 = $urandom();
        if (r[20]) begin lo0[0] = r[21]; lo1[0] = r[21]; end
        tlb_write(r[0] ? WR : WI, r[4:1], {pool_vpn($urandom_range(0, 7)), r[12:8], 8'(r[6:5])},
                  lo0, lo1, $urandom(), $urandom_range(0, 3) == 0);
      end else begin
        @(negedge clk);
        r = $urandom();
        entry_hi_W = {pool_vpn($urandom_range(0, 7)), r[12:8], 8'(r[14:13])};
        index_W = $urandom();
        tlb_typeM = 4'(r[16:15]);
        r = $urandom();
        inst_vaddr = (r[31:29] == 3'b0) ? {2'b10, r[29:0]} : {pool_vpn($urandom_range(0, 7)), r[12:0]};
        r = $urandom();
        data_vaddr = (r[31:29] == 3'b0) ? {2'b10, r[29:0]} : {pool_vpn($urandom_range(0, 7)), r[12:0]};
        data_en = r[20]; data_wr = r[21];
        #1;
        model_xlate(inst_vaddr, entry_hi_W[7:0], 1'b1, 1'b0, e_pa, e_unc, e_rf, e_iv, e_md);
        n_total++; if ({inst_paddr, inst_uncached, inst_refill, inst_invalid} !== {e_pa, e_unc, e_rf, e_iv})
          $display("FAIL rnd_inst va=%h: got %h/%b%b%b want %h/%b%b%b", inst_vaddr, inst_paddr, inst_uncached, inst_refill, inst_invalid, e_pa, e_unc, e_rf, e_iv); else n_pass++;
        model_xlate(data_vaddr, entry_hi_W[7:0], data_en, data_wr, e_pa, e_unc, e_rf, e_iv, e_md);
        n_total++; if ({data_paddr, data_uncached, data_refill, data_invalid, data_modified} !== {e_pa, e_unc, e_rf, e_iv, e_md})
          $display("FAIL rnd_data va=%h: got %h/%b%b%b%b want %h/%b%b%b%b", data_vaddr, data_paddr, data_uncached, data_refill, data_invalid, data_modified, e_pa, e_unc, e_rf, e_iv, e_md); else n_pass++;
        model_find(entry_hi_W[31:13], entry_hi_W[7:0], found, k);
        n_total++; if (index_in !== (found ? 32'(k) : 32'h8000_0000))
          $display("FAIL rnd_tlbp hi=%h: got %h want %h", entry_hi_W, index_in, found ? 32'(k) : 32'h8000_0000); else n_pass++;
        k = int'(index_W[3:0]);
        n_total++; if ({entry_hi_in, entry_lo0_in, entry_lo1_in, page_mask_in} !==
                       {m_vpn2[k], 5'b0, m_asid[k],
                        6'b0, m_pfn[k][0], m_c[k][0], m_d[k][0], m_v[k][0], m_g[k],
                        6'b0, m_pfn[k][1], m_c[k][1], m_d[k][1], m_v[k][1], m_g[k],
                        7'b0, m_mask[k], 13'b0})
          $display("FAIL rnd_tlbr idx=%0d: got %h %h %h %h", k, entry_hi_in, entry_lo0_in, entry_lo1_in, page_mask_in); else n_pass++;
        tlb_typeM = 4'b0;
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; tlb_typeM = WI; index_W = 32'd3; stallM = 1'b0;
    entry_hi_W = 32'h0040_0001; entry_lo0_W = 32'h0000_1017; entry_lo1_W = 32'h0000_1057;
    @(posedge clk);
    #1;
    rst = 1'b0; tlb_typeM = 4'b0;
    model_clear();
    #1;
    n_total++; if ({entry_hi_in, entry_lo0_in, entry_lo1_in} !== 96'h0) $display("FAIL rst_vs_write: got %h want 0", {entry_hi_in, entry_lo0_in, entry_lo1_in}); else n_pass++;
    n_total++; if (index_in !== 32'h8000_0000) $display("FAIL rst_tlbp: got %h want 80000000", index_in); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; stallM = 1'b0; tlb_typeM = 4'b0;
    entry_hi_W = '0; entry_lo0_W = '0; entry_lo1_W = '0; page_mask_W = '0;
    index_W = '0; random_W = '0; inst_vaddr = '0; data_vaddr = '0;
    data_en = 1'b0; data_wr = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_tlbwi();
    test_priority();
    test_modified();
    test_asid();
    test_invalid();
    test_tlbwr();
    test_kseg();
    test_random();
    test_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
